// File: rtl/layer0_mac.sv
// Layer-0 MNIST multiply-accumulate engine: 128 parallel Q16.16 dot products over a 784-row weight stream.
// Define LAYER0_RELU_EN to apply ReLU to the saturated outputs.
module layer0_mac #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 128,
  parameter int W     = 32,
  parameter int FRAC  = 16
) (
  input  logic                     clka,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     w_start,
  input  logic [N_OUT*W-1:0]       w_values,
  output logic [$clog2(N_IN)-1:0]  act_addr,
  input  logic [W-1:0]             act_data,
  output logic                     busy,
  output logic                     done,
  output logic [N_OUT*W-1:0]       result
);

  localparam int AW    = $clog2(N_IN);
  localparam int ACC_W = 2*W - FRAC + AW;
  localparam logic [AW-1:0] LAST_ROW = AW'(N_IN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;
  logic signed [ACC_W-1:0] acc_r [N_OUT];

  // One row contribution: full-width signed product rescaled back to Q16.16.
  function automatic logic signed [ACC_W-1:0] prod_term(input logic signed [W-1:0] w,
                                                        input logic signed [W-1:0] a);
    logic signed [2*W-1:0] p;
    p = w * a;
    return ACC_W'(p >>> FRAC);
  endfunction

  // Clamp to the W-bit signed range; optional ReLU afterwards.
  function automatic logic [W-1:0] sat_lane(input logic signed [ACC_W-1:0] a);
    logic [W-1:0] r;
    if (a[ACC_W-1:W-1] == {(ACC_W-W+1){a[ACC_W-1]}}) begin
      r = a[W-1:0];
    end else begin
      r = a[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`ifdef LAYER0_RELU_EN
    r = r[W-1] ? {W{1'b0}} : r;
`endif
    return r;
  endfunction

  // State register.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and the combinational weight-store start strobe.
  always_comb begin
    state_s = state_r;
    w_start = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && rst_n) begin
          w_start = 1'b1;
          state_s = ACCUM;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (act_addr == LAST_ROW) begin
          state_s = FINISH;
        end else begin
          state_s = ACCUM;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: act_addr doubles as the row counter while accumulating.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      act_addr <= {AW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= {(N_OUT*W){1'b0}};
      for (int j = 0; j < N_OUT; j++) begin
        acc_r[j] <= {ACC_W{1'b0}};
      end
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            act_addr <= {AW{1'b0}};
            busy     <= 1'b1;
            for (int j = 0; j < N_OUT; j++) begin
              acc_r[j] <= {ACC_W{1'b0}};
            end
          end
        end
        ACCUM: begin
          for (int j = 0; j < N_OUT; j++) begin
            acc_r[j] <= acc_r[j] + prod_term(w_values[j*W +: W], act_data);
          end
          act_addr <= (act_addr == LAST_ROW) ? {AW{1'b0}} : act_addr + AW'(1);
        end
        FINISH: begin
          for (int j = 0; j < N_OUT; j++) begin
            result[j*W +: W] <= sat_lane(acc_r[j]);
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/layer0_mac.md
# layer0_mac

Layer-0 multiply-accumulate engine for the MNIST network; sits directly downstream of the weights store. On one `start` pulse it requests the 784-row layer-0 weight stream and fetches one input activation per cycle, aligned to the rows. It accumulates 128 signed fixed-point dot products in parallel and presents the 128 saturated hidden-layer activations with a one-cycle `done` pulse.

## Interface
Parameters:
- `N_IN`, 784, rows streamed from the weight store (input pixels).
- `N_OUT`, 128, lanes per weight row (hidden neurons).
- `W`, 32, lane/activation width, signed two's complement.
- `FRAC`, 16, fractional bits (Q16.16).

Ports (one clock; reset is asynchronous and active-low):
- `clka`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to run a layer pass; ignored unless idle.
- `w_start`  out  1  combinational; drives the weight store's layer-0 start; high only in the cycle `start` is accepted.
- `w_values`  in  N_OUT*W  current weight row; lane j = bits [j*W +: W].
- `act_addr`  out  $clog2(N_IN)  registered activation read address.
- `act_data`  in  W  activation at `act_addr`, combinational (same-cycle) read.
- `busy`  out  1  high from the accept edge until `done` is asserted.
- `done`  out  1  one-cycle pulse; `result` valid from this cycle.
- `result`  out  N_OUT*W  lane j = output of neuron j; held until the next `done`.

## Operation
- States: IDLE, ACCUM, FINISH.
- IDLE:
  - `start`=1 asserts `w_start` combinationally in the same cycle.
  - At the edge: clear all accumulators, `act_addr`<=0, row counter<=0, `busy`<=1, go to ACCUM.
- ACCUM, one edge per row k = 0..N_IN-1:
  - acc[j] += (w_values lane j * act_data) >>> FRAC; signed multiply, W*2-bit product, arithmetic shift.
  - `act_addr`<=k+1.
  - At k==N_IN-1, go to FINISH with `act_addr`<=0.
- Accumulator width: 2*W-FRAC+$clog2(N_IN) bits, so it cannot overflow.
- FINISH, one edge:
  - result lane j <= acc[j] saturated to W bits (clamp to 0x7FFFFFFF / 0x80000000).
  - `done`<=1, `busy`<=0, go to IDLE.
- `done` clears on the next edge.
- `start` during ACCUM/FINISH: ignored, no `w_start`.
- `start` in the cycle `done` is high: the block is already in IDLE, so the request is accepted.
- `act_addr` is 0 whenever not in ACCUM.

## Timing
- Accept edge e0 (IDLE with `start`=1). The weight store samples `w_start` at e0 and presents row k after edge e0+k.
- In the cycle after edge e0+k, `act_addr`=k and `w_values`=row k.
- Row k is accumulated at edge e0+k+1.
- Result registered at e0+785; `done` high in the cycle after e0+785, i.e. N_IN+1 edges after acceptance.
- Reset values: `busy`=0, `done`=0, `result`=0, `act_addr`=0, state IDLE, accumulators 0.
- `w_start`=0 while `rst_n`=0.
- Reset mid-pass: immediate return to IDLE and all outputs to their reset values. No `done` is produced. The weight store is reset by the same system reset.

## Configuration
- `LAYER0_RELU_EN` defined: FINISH applies ReLU after saturation; negative lanes are written as 0.
- `LAYER0_RELU_EN` undefined: the saturated signed value is written unchanged.

## Test plan
- Unity pass: every weight lane 0x00010000, every activation 0x00010000, `start` pulse.
  - `w_start` high exactly in the `start` cycle.
  - `act_addr` steps 0..783.
  - Every result lane 0x03100000 (784.0).
  - `done` exactly 785 edges after accept, one cycle wide.
- Negative lane: lane 0 weights 0xFFFF0000 (-1.0), others 0.5, activations 1.0.
  - Without RELU_EN: lane 0 = 0xFCF00000, others 0x01880000.
  - With RELU_EN: lane 0 = 0.
- Saturation: all weights 0x7FFFFFFF, activations 0x7FFF0000 → every lane 0x7FFFFFFF. With weights 0x80000000 → 0x80000000, or 0 with RELU_EN.
- Handshake:
  - `start` re-pulsed at row 100 → ignored, no second `w_start`, result unchanged.
  - `start` in the `done` cycle → second pass accepted and completes 785 edges later.
- Reset mid-pass: drop `rst_n` at row 300.
  - `busy`=0, `act_addr`=0, `result`=0, no `done`.
  - A following unity pass yields 0x03100000 in all lanes.
